// File: rtl/uart_rx_fifo_pkg.sv
// Shared UART definitions: byte width, default FIFO geometry and peripheral register offsets.
package uart_rx_fifo_pkg;
    localparam int BYTE_W            = 8;
    localparam int DEFAULT_DEPTH     = 16;
    localparam int DEFAULT_DEPTH_BIT = 4;

    typedef enum logic [3:0] {
        REG_RX_DATA   = 4'h0,
        REG_RX_STATUS = 4'h4,
        REG_OVF_CLR   = 4'h8
    } reg_offset_e;
endpackage

// File: rtl/uart_fifo_ram.sv
// DEPTH x 8 storage for the RX FIFO: one synchronous write port, one asynchronous read port.
module uart_fifo_ram
    import uart_rx_fifo_pkg::*;
#(
    parameter int DEPTH     = DEFAULT_DEPTH,
    parameter int DEPTH_BIT = DEFAULT_DEPTH_BIT
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [DEPTH_BIT-1:0] waddr,
    input  logic [BYTE_W-1:0]    wdata,
    input  logic [DEPTH_BIT-1:0] raddr,
    output logic [BYTE_W-1:0]    rdata
);
    logic [BYTE_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Show-ahead read: the head byte is visible without a read cycle.
    assign rdata = mem[raddr];
endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO with sticky overflow flag and level interrupt.
// Optional feature: define UART_RX_FIFO_IRQ_EN to enable the registered occupancy/overflow irq.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int DEPTH     = DEFAULT_DEPTH,
    parameter int DEPTH_BIT = DEFAULT_DEPTH_BIT,
    parameter int IRQ_LEVEL = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [BYTE_W-1:0]    in_data,
    input  logic                 pop,
    input  logic                 clr_ovf,
    output logic [BYTE_W-1:0]    rd_data,
    output logic                 empty,
    output logic                 full,
    output logic [DEPTH_BIT:0]   count,
    output logic                 overflow,
    output logic                 irq
);
    localparam logic [DEPTH_BIT:0] FULL_CNT = DEPTH[DEPTH_BIT:0];
    localparam logic [DEPTH_BIT:0] ONE      = {{DEPTH_BIT{1'b0}}, 1'b1};

    generate
        if (DEPTH != (1 << DEPTH_BIT) || IRQ_LEVEL < 1 || IRQ_LEVEL > DEPTH) begin : g_bad_cfg
            $error("uart_rx_fifo: inconsistent DEPTH/DEPTH_BIT/IRQ_LEVEL");
        end
    endgenerate

    logic [DEPTH_BIT-1:0] wptr_reg, rptr_reg;
    logic [DEPTH_BIT:0]   count_reg, count_next;
    logic                 overflow_reg, overflow_next;
    logic                 do_push, do_pop, drop;
    logic [BYTE_W-1:0]    ram_q;

    assign empty    = (count_reg == '0);
    assign full     = (count_reg == FULL_CNT);
    assign count    = count_reg;
    assign overflow = overflow_reg;
    assign rd_data  = empty ? '0 : ram_q;

    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    assign do_push = in_valid && (!full || pop);
    assign do_pop  = pop && !empty;
    assign drop    = in_valid && full && !pop;

    always_comb begin
        count_next = count_reg;
        if (do_push && !do_pop) begin
            count_next = count_reg + ONE;
        end else if (!do_push && do_pop) begin
            count_next = count_reg - ONE;
        end
        // Set beats clear when both land on the same edge.
        overflow_next = drop ? 1'b1 : (clr_ovf ? 1'b0 : overflow_reg);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_reg     <= '0;
            rptr_reg     <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (do_push) wptr_reg <= wptr_reg + 1'b1;
            if (do_pop)  rptr_reg <= rptr_reg + 1'b1;
            count_reg    <= count_next;
            overflow_reg <= overflow_next;
        end
    end

`ifdef UART_RX_FIFO_IRQ_EN
    localparam logic [DEPTH_BIT:0] IRQ_THR = IRQ_LEVEL[DEPTH_BIT:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq <= 1'b0;
        end else begin
            irq <= (count_next >= IRQ_THR) || overflow_next;
        end
    end
`else
    assign irq = 1'b0;
`endif

    uart_fifo_ram #(
        .DEPTH     (DEPTH),
        .DEPTH_BIT (DEPTH_BIT)
    ) u_ram (
        .clk   (clk),
        .we    (do_push),
        .waddr (wptr_reg),
        .wdata (in_data),
        .raddr (rptr_reg),
        .rdata (ram_q)
    );
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo (default DEPTH=16, IRQ_LEVEL=8).
module tb_uart_rx_fifo;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       pop = 1'b0;
    logic       clr_ovf = 1'b0;
    logic [7:0] rd_data;
    logic       empty, full, overflow, irq;
    logic [4:0] count;

    int tests = 0;
    int failed = 0;

    uart_rx_fifo dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_data  (in_data),
        .pop      (pop),
        .clr_ovf  (clr_ovf),
        .rd_data  (rd_data),
        .empty    (empty),
        .full     (full),
        .count    (count),
        .overflow (overflow),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present inputs for one rising edge, then sample 1 time unit after it.
    task automatic step(input logic v, input logic [7:0] d, input logic p, input logic c);
        in_valid = v;
        in_data  = d;
        pop      = p;
        clr_ovf  = c;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        pop      = 1'b0;
        clr_ovf  = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_count", count, 0);
        check("rst_rd_data", rd_data, 8'h00);
        check("rst_overflow", overflow, 0);
        check("rst_irq", irq, 0);
        reset = 1'b0;

        // Two pushes, head shows first byte
        step(1, 8'hA5, 0, 0);
        check("push1_rd_data", rd_data, 8'hA5);
        step(1, 8'h3C, 0, 0);
        check("push2_count", count, 2);
        check("push2_rd_data", rd_data, 8'hA5);
        step(0, 8'h00, 1, 0);
        check("pop1_rd_data", rd_data, 8'h3C);
        check("pop1_count", count, 1);
        step(0, 8'h00, 1, 0);
        check("pop2_empty", empty, 1);

        // Fill to full, then overflow
        for (int i = 0; i < 16; i++) step(1, 8'(i), 0, 0);
        check("fill_full", full, 1);
        check("fill_count", count, 16);
        check("fill_overflow", overflow, 0);
        step(1, 8'hFF, 0, 0);
        check("ovf_set", overflow, 1);
        check("ovf_count", count, 16);
        check("ovf_head", rd_data, 8'h00);
        step(1, 8'hEE, 0, 1);
        check("ovf_set_beats_clr", overflow, 1);
        check("ovf_drop_count", count, 16);
        step(0, 8'h00, 0, 1);
        check("ovf_clr", overflow, 0);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("drain_%0d", i), rd_data, 32'(i));
            step(0, 8'h00, 1, 0);
        end
        check("drain_empty", empty, 1);
        check("drain_rd_zero", rd_data, 8'h00);

        // Push + pop while full: no overflow, new byte goes last
        for (int i = 0; i < 16; i++) step(1, 8'(8'h10 + i), 0, 0);
        step(1, 8'h77, 1, 0);
        check("fullpp_overflow", overflow, 0);
        check("fullpp_count", count, 16);
        check("fullpp_head", rd_data, 8'h11);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("fullpp_drain_%0d", i), rd_data, (i == 15) ? 32'h77 : 32'(8'h11 + i));
            step(0, 8'h00, 1, 0);
        end
        check("fullpp_empty", empty, 1);

        // Push + pop while empty
        step(1, 8'h42, 1, 0);
        check("emptypp_count", count, 1);
        check("emptypp_rd_data", rd_data, 8'h42);
        step(0, 8'h00, 1, 0);
        check("emptypp_pop_empty", empty, 1);
        step(0, 8'h00, 1, 0);
        check("pop_on_empty_count", count, 0);
        check("pop_on_empty_empty", empty, 1);
        check("pop_on_empty_ovf", overflow, 0);

        // Interrupt threshold
        for (int i = 0; i < 7; i++) step(1, 8'(8'h50 + i), 0, 0);
        check("irq_at7", irq, 0);
        step(1, 8'h57, 0, 0);
`ifdef UART_RX_FIFO_IRQ_EN
        check("irq_at8", irq, 1);
`else
        check("irq_at8_disabled", irq, 0);
`endif
        step(0, 8'h00, 1, 0);
        check("irq_after_pop", irq, 0);
        check("irq_pop_count", count, 7);

        // Asynchronous reset mid-cycle flushes immediately
        reset = 1'b1;
        #1;
        check("async_rst_count", count, 0);
        check("async_rst_empty", empty, 1);
        check("async_rst_rd_data", rd_data, 8'h00);

        // in_valid while reset is held is not captured; captured once reset is low
        in_valid = 1'b1;
        in_data  = 8'h5A;
        @(posedge clk);
        #1;
        check("rst_hold_no_capture", count, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("post_rst_capture_count", count, 1);
        check("post_rst_capture_data", rd_data, 8'h5A);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
